// File: rtl/parity_frame_serializer_if.sv
// ---------------------------------------------------------------------------
// parity_frame_serializer_if
//
// Purpose: bundles the load handshake and the serial output stream of the
// parity frame serializer so both sides connect through one port.
//
// Signals:
//   data_in      WIDTH  parallel word to send (upstream -> serializer)
//   load_valid   1      upstream has a word on data_in
//   load_ready   1      serializer can accept a word (it is idle)
//   out_bit      1      serial data, LSB first, then optional parity bit
//   bit_valid    1      out_bit carries a frame bit this cycle
//   frame_start  1      cycle carrying the first data bit
//   frame_end    1      cycle carrying the last frame bit
//   busy         1      a frame is in progress
//   state_dbg    2      current FSM state, for observation only
//
// Handshake: a word is transferred at a rising clock edge where both
// load_valid and load_ready are 1. load_valid is ignored while load_ready
// is 0, and load_ready depends only on the serializer state, never on
// load_valid, so upstream may hold load_valid high across frames.
//
// Modports:
//   master  upstream / stimulus side
//   slave   the serializer itself
// ---------------------------------------------------------------------------
interface parity_frame_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             load_valid;
    logic             load_ready;
    logic             out_bit;
    logic             bit_valid;
    logic             frame_start;
    logic             frame_end;
    logic             busy;
    logic [1:0]       state_dbg;

    modport master (
        output data_in,
        output load_valid,
        input  load_ready,
        input  out_bit,
        input  bit_valid,
        input  frame_start,
        input  frame_end,
        input  busy,
        input  state_dbg
    );

    modport slave (
        input  data_in,
        input  load_valid,
        output load_ready,
        output out_bit,
        output bit_valid,
        output frame_start,
        output frame_end,
        output busy,
        output state_dbg
    );
endinterface

// File: rtl/parity_frame_serializer.sv
// ---------------------------------------------------------------------------
// parity_frame_serializer
//
// Purpose: accepts a WIDTH-bit word and emits it serially, LSB first, one
// bit per clock, optionally followed by an even-parity bit. Frames are
// marked with frame_start / frame_end; at least one idle cycle separates
// consecutive frames.
//
// Parameters:
//   WIDTH      data bits per frame, legal range 2..32
//   PARITY_EN  1 appends an even-parity bit, 0 omits it
//
// Ports:
//   clk    input  single clock, all state updates on the rising edge
//   reset  input  synchronous active-high reset
//   bus    slave modport of parity_frame_serializer_if
//            (data_in, load_valid, load_ready, out_bit, bit_valid,
//             frame_start, frame_end, busy, state_dbg)
// ---------------------------------------------------------------------------
module parity_frame_serializer #(
    parameter int WIDTH     = 8,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    parity_frame_serializer_if.slave   bus
);

    // Counter wide enough to index WIDTH bits, never narrower than one bit.
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   shreg;
    logic [WIDTH-1:0]   shreg_next;
    logic               par;
    logic               par_next;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;

    logic               accept;
    logic               last_data;
    logic               load_ready;
    logic               out_bit;
    logic               bit_valid;
    logic               frame_start;
    logic               frame_end;
    logic               busy;

    // -----------------------------------------------------------------------
    // State register. Reset overrides any accept or shift in the same cycle.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            shreg <= '0;
            par   <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            shreg <= shreg_next;
            par   <= par_next;
            cnt   <= cnt_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and output decode.
    // -----------------------------------------------------------------------
    assign load_ready = (state == IDLE);
    assign accept     = bus.load_valid & load_ready;
    assign last_data  = (cnt == CNT_LAST);

    always_comb begin
        state_next  = state;
        shreg_next  = shreg;
        par_next    = par;
        cnt_next    = cnt;
        out_bit     = 1'b0;
        bit_valid   = 1'b0;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        busy        = 1'b0;

        case (state)
            IDLE: begin
                if (accept) begin
                    // Parity is captured with the word so later changes on
                    // data_in cannot disturb the frame in flight.
                    shreg_next = bus.data_in;
                    par_next   = ^bus.data_in;
                    cnt_next   = '0;
                    state_next = SHIFT;
                end
            end

            SHIFT: begin
                out_bit     = shreg[0];
                bit_valid   = 1'b1;
                busy        = 1'b1;
                frame_start = (cnt == '0);
                shreg_next  = shreg >> 1;
                if (last_data) begin
                    // Park the counter at zero instead of letting it step
                    // past WIDTH-1 on non-power-of-two widths.
                    cnt_next = '0;
                    if (PARITY_EN) begin
                        state_next = PARITY;
                    end else begin
                        frame_end  = 1'b1;
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end

            PARITY: begin
                out_bit    = par;
                bit_valid  = 1'b1;
                frame_end  = 1'b1;
                busy       = 1'b1;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.load_ready  = load_ready;
    assign bus.out_bit     = out_bit;
    assign bus.bit_valid   = bit_valid;
    assign bus.frame_start = frame_start;
    assign bus.frame_end   = frame_end;
    assign bus.busy        = busy;
    assign bus.state_dbg   = state;

endmodule

// File: doc/parity_frame_serializer.md
PARITY_FRAME_SERIALIZER -- requirements
Module: parity_frame_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, data bits per frame, legal range 2..32.
REQ-002 The block SHALL have parameter PARITY_EN, default 1; 1 appends an even-parity bit, 0 omits it.
REQ-003 Port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 Port reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 Port data_in  input  WIDTH  parallel word; sampled only on an accepted load.
REQ-006 Port load_valid  input  1  upstream asserts when data_in holds a word to send.
REQ-007 Port load_ready  output  1  high when the block can accept a word.
REQ-008 Port out_bit  output  1  serial bit stream toward the serial parity-check stage.
REQ-009 Port bit_valid  output  1  high in every cycle where out_bit carries a frame bit.
REQ-010 Port frame_start  output  1  high only in the cycle carrying the first data bit.
REQ-011 Port frame_end  output  1  high only in the cycle carrying the last frame bit.
REQ-012 Port busy  output  1  high while a frame is in progress (state not IDLE).

Function
REQ-013 The FSM SHALL have states IDLE, SHIFT, PARITY; PARITY is unreachable when PARITY_EN=0.
REQ-014 load_ready SHALL equal (state == IDLE), decoded combinationally from state; load_valid is ignored when load_ready=0.
REQ-015 An accept occurs at a posedge with load_valid=1 and load_ready=1; it SHALL load shreg<=data_in, par<=XOR-reduce(data_in), cnt<=0, state<=SHIFT.
REQ-016 In SHIFT, out_bit SHALL equal shreg[0] (LSB first); bit_valid=1; frame_start=1 only when cnt==0.
REQ-017 Each posedge in SHIFT SHALL shift shreg right by one (zero fill) and increment cnt.
REQ-018 At a posedge in SHIFT with cnt==WIDTH-1, state SHALL go to PARITY if PARITY_EN=1, else IDLE.
REQ-019 In PARITY, out_bit SHALL equal par, bit_valid=1, frame_end=1; the next posedge SHALL go to IDLE.
REQ-020 With PARITY_EN=0, frame_end SHALL be 1 in the SHIFT cycle with cnt==WIDTH-1.
REQ-021 Even parity: the count of 1s over all WIDTH data bits plus the parity bit SHALL be even.
REQ-022 In IDLE, out_bit, bit_valid, frame_start, frame_end and busy SHALL be 0.
REQ-023 Frame length SHALL be WIDTH+PARITY_EN cycles, followed by at least one IDLE cycle; back-to-back accepts yield exactly one gap cycle.
REQ-024 cnt SHALL be ceil(log2(WIDTH)) bits wide, at least 1 bit, and SHALL never exceed WIDTH-1.
REQ-025 Changes on data_in after an accept SHALL NOT affect the frame in progress.

Reset
REQ-026 When reset=1 at a posedge, state SHALL become IDLE and shreg, par and cnt SHALL become 0, overriding any accept or shift in that cycle.
REQ-027 After reset: load_ready=1; out_bit, bit_valid, frame_start, frame_end and busy all 0.
REQ-028 A reset mid-frame SHALL abort the frame with no further bit_valid; the next accept starts a fresh frame.

Verification
REQ-029 WIDTH=8, PARITY_EN=1, accept 8'hB4 -> out_bit 0,0,1,0,1,1,0,1 then parity 0; frame_start in cycle 1, frame_end in cycle 9, 9 bit_valid cycles.
REQ-030 Accept 8'h07 -> data bits 1,1,1,0,0,0,0,0 then parity 1; the serial parity-check stage, reset before the frame and fed this stream, ends the frame with its even-parity output =1.
REQ-031 load_valid held high with words 8'hFF then 8'h00 -> frames of 9 cycles separated by exactly one cycle with bit_valid=0; parity bits 0 and 0.
REQ-032 PARITY_EN=0, WIDTH=4, accept 4'hA -> out_bit 0,1,0,1; frame_end on the 4th bit; load_ready high on the next cycle.
REQ-033 Reset asserted after 3 bits of a frame -> next cycle IDLE, all outputs 0, load_ready=1; a following accept of 8'h01 emits 1,0,0,0,0,0,0,0 and parity 1.
REQ-034 load_valid pulsed while busy=1 with 8'h55 -> word not accepted; the frame in progress is unaltered; no extra frame is emitted.
